alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_cond_eval.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the sequenced ALU controller: ALU codes,
// condition codes, FSM state type and NZCV bit positions.
package alu_pkg;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit positions inside the {N,Z,C,V} status register.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational evaluation of a 4-bit condition code against the NZCV flags.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer that issues one command to an external combinational ALU and returns
// its result. Conditional execution is compiled in only with ALU_COND_EXEC_EN.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DATA_W-1:0]  cmd_op0,
    input  logic [DATA_W-1:0]  cmd_op1,
    input  logic [2:0]         cmd_control,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic [3:0]         cmd_cond,
    input  logic               cmd_set_flags,

    output logic [DATA_W-1:0]  alu_operand0,
    output logic [DATA_W-1:0]  alu_operand1,
    output logic [2:0]         alu_control,
    output logic [SHIFT_W-1:0] alu_shift,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_Z,
    input  logic               alu_V,
    input  logic               alu_C,
    input  logic               alu_N,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_skipped,
    output logic [3:0]         flags_nzcv,
    output logic               busy
);

    state_e state_q, state_d;

    logic [DATA_W-1:0]  op0_q, op1_q;
    logic [2:0]         control_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [3:0]         cond_q;
    logic               set_flags_q;
    logic [DATA_W-1:0]  rsp_result_q;
    logic [3:0]         flags_q;
    logic               accept;
    logic               exec_pass;

    assign accept = cmd_valid && cmd_ready;

`ifdef ALU_COND_EXEC_EN
    logic rsp_skipped_q;

    alu_cond_eval u_cond_eval (
        .flags (flags_q),
        .cond  (cond_q),
        .pass  (exec_pass)
    );

    assign rsp_skipped = rsp_skipped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_skipped_q <= 1'b0;
        end else if (state_q == StIssue) begin
            rsp_skipped_q <= !exec_pass;
        end
    end
`else
    logic unused_cond;

    assign unused_cond = ^cond_q;
    assign exec_pass   = 1'b1;
    assign rsp_skipped = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready    = (state_q == StIdle);
        busy         = (state_q != StIdle);
        rsp_valid    = (state_q == StResp);
        alu_operand0 = '0;
        alu_operand1 = '0;
        alu_control  = ALU_NOP;
        alu_shift    = '0;
        if (state_q == StIssue) begin
            alu_operand0 = op0_q;
            alu_operand1 = op1_q;
            alu_control  = control_q;
            alu_shift    = shift_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op0_q       <= '0;
            op1_q       <= '0;
            control_q   <= ALU_NOP;
            shift_q     <= '0;
            cond_q      <= COND_AL;
            set_flags_q <= 1'b0;
        end else if (accept) begin
            op0_q       <= cmd_op0;
            op1_q       <= cmd_op1;
            control_q   <= cmd_control;
            shift_q     <= cmd_shift;
            cond_q      <= cmd_cond;
            set_flags_q <= cmd_set_flags;
        end
    end

    // Result and flags are captured only on the ISSUE edge, so they hold through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            flags_q      <= 4'b0000;
        end else if (state_q == StIssue) begin
            if (exec_pass) begin
                rsp_result_q <= alu_result;
                if (set_flags_q) begin
                    flags_q <= {alu_N, alu_Z, alu_C, alu_V};
                end
            end else begin
                rsp_result_q <= '0;
            end
        end
    end

    assign rsp_result = rsp_result_q;
    assign flags_nzcv = flags_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU on the alu_* side.
// Expectations follow ALU_COND_EXEC_EN when the macro is defined.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_op0, cmd_op1;
    logic [2:0]  cmd_control;
    logic [5:0]  cmd_shift;
    logic [3:0]  cmd_cond;
    logic        cmd_set_flags;
    logic [31:0] alu_operand0, alu_operand1, alu_result;
    logic [2:0]  alu_control;
    logic [5:0]  alu_shift;
    logic        alu_Z, alu_V, alu_C, alu_N;
    logic        rsp_valid, rsp_ready, rsp_skipped, busy;
    logic [31:0] rsp_result;
    logic [3:0]  flags_nzcv;

    typedef struct packed {
        logic [31:0] result;
        logic        skipped;
        logic [3:0]  flags;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_flags;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DATA_W(32), .SHIFT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op0       (cmd_op0),
        .cmd_op1       (cmd_op1),
        .cmd_control   (cmd_control),
        .cmd_shift     (cmd_shift),
        .cmd_cond      (cmd_cond),
        .cmd_set_flags (cmd_set_flags),
        .alu_operand0  (alu_operand0),
        .alu_operand1  (alu_operand1),
        .alu_control   (alu_control),
        .alu_shift     (alu_shift),
        .alu_result    (alu_result),
        .alu_Z         (alu_Z),
        .alu_V         (alu_V),
        .alu_C         (alu_C),
        .alu_N         (alu_N),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_skipped   (rsp_skipped),
        .flags_nzcv    (flags_nzcv),
        .busy          (busy)
    );

    // Returns {N,Z,C,V,result}; SUB sets C when no borrow occurs.
    function automatic logic [35:0] alu_model(input logic [2:0] ctl, input logic [31:0] a,
                                              input logic [31:0] b, input logic [5:0] sh);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        r = 32'h0;
        case (ctl)
            3'b001: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b010: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b011: r = a & b;
            3'b100: r = a | b;
            3'b101: r = a ^ b;
            3'b110: r = {31'h0, ($signed(a) < $signed(b))};
            3'b111: r = (sh >= 6'd32) ? 32'h0 : (a << sh);
            default: r = 32'h0;
        endcase
        if (ctl == 3'b000) return 36'h0;
        return {r[31], (r == 32'h0), c, v, r};
    endfunction

    function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] cond);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    assign {alu_N, alu_Z, alu_C, alu_V, alu_result} =
        alu_model(alu_control, alu_operand0, alu_operand1, alu_shift);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_spurious_rsp", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("rsp_result", rsp_result, e.result);
                check_eq("rsp_skipped", rsp_skipped, e.skipped);
                check_eq("flags_nzcv", flags_nzcv, e.flags);
            end
        end
    end

    // Drives one command, pushes its expectation and checks the issue/latency timing.
    // Returns #1 after the edge that enters RESP.
    task automatic send(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sh, input logic [3:0] cond, input logic sf);
        logic [35:0] m;
        logic        pass;
        exp_t        e;
`ifdef ALU_COND_EXEC_EN
        pass = cond_ok(exp_flags, cond);
`else
        pass = 1'b1;
`endif
        m = alu_model(ctl, a, b, sh);
        if (pass) begin
            e.result  = m[31:0];
            e.skipped = 1'b0;
            if (sf) exp_flags = m[35:32];
        end else begin
            e.result  = 32'h0;
            e.skipped = 1'b1;
        end
        e.flags = exp_flags;
        sb.push_back(e);

        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_op0       = a;
        cmd_op1       = b;
        cmd_control   = ctl;
        cmd_shift     = sh;
        cmd_cond      = cond;
        cmd_set_flags = sf;
        check_eq("cmd_ready_idle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("issue_busy", busy, 1'b1);
        check_eq("issue_no_rsp", rsp_valid, 1'b0);
        check_eq("issue_alu_ctl", alu_control, ctl);
        check_eq("issue_alu_op0", alu_operand0, a);
        check_eq("issue_alu_op1", alu_operand1, b);
        check_eq("issue_alu_sh", alu_shift, sh);
        @(posedge clk);
        #1;
        check_eq("resp_valid_lat", rsp_valid, 1'b1);
        check_eq("resp_alu_idle", alu_control, 3'b000);
    endtask

    task automatic run_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] sh, input logic [3:0] cond, input logic sf);
        send(ctl, a, b, sh, cond, sf);
        @(posedge clk);
        #1;
        check_eq("back_to_idle", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op0 = '0;
        cmd_op1 = '0;
        cmd_control = '0;
        cmd_shift = '0;
        cmd_cond = '0;
        cmd_set_flags = 1'b0;
        rsp_ready = 1'b1;
        exp_flags = 4'b0000;
        #3;
        check_eq("rst_flags", flags_nzcv, 4'b0000);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_alu_op0", alu_operand0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow on ADD.
        run_op(3'b001, 32'h7FFF_FFFF, 32'h1, 6'd0, 4'hE, 1'b1);
        check_eq("ovf_flags", flags_nzcv, 4'b1001);

        // SUB sets Z, then a conditional ADD under NE and under EQ.
        run_op(3'b010, 32'd5, 32'd5, 6'd0, 4'hE, 1'b1);
        check_eq("sub_z_flags", flags_nzcv, 4'b0110);
        run_op(3'b001, 32'd3, 32'd4, 6'd0, 4'h1, 1'b0);
        run_op(3'b010, 32'd5, 32'd5, 6'd0, 4'hE, 1'b1);
        run_op(3'b001, 32'd3, 32'd4, 6'd0, 4'h0, 1'b0);
        check_eq("eq_flags_kept", flags_nzcv, 4'b0110);

        run_op(3'b011, 32'hF0F0_1234, 32'h0FF0_FFFF, 6'd0, 4'hE, 1'b1);
        run_op(3'b100, 32'h8000_0000, 32'h1, 6'd0, 4'h4, 1'b1);
        run_op(3'b101, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 6'd0, 4'hF, 1'b1);
        run_op(3'b110, 32'hFFFF_FFFF, 32'h1, 6'd0, 4'h0, 1'b0);
        run_op(3'b111, 32'h0000_0003, 32'h0, 6'd31, 4'hE, 1'b1);
        run_op(3'b111, 32'h0000_0003, 32'h0, 6'd40, 4'hE, 1'b0);

        // NOP with set_flags clears the status register.
        run_op(3'b010, 32'd1, 32'd2, 6'd0, 4'hE, 1'b1);
        run_op(3'b000, 32'h1234, 32'h5678, 6'd3, 4'hE, 1'b1);
        check_eq("nop_clears_flags", flags_nzcv, 4'b0000);

        // Back-pressure: response held, a second command ignored.
        run_op(3'b010, 32'd2, 32'd1, 6'd0, 4'hE, 1'b1);
        rsp_ready = 1'b0;
        send(3'b001, 32'h1111_1111, 32'h2222_2222, 6'd0, 4'hE, 1'b0);
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_control = 3'b000;
            cmd_set_flags = 1'b1;
            cmd_cond = 4'hE;
            @(posedge clk);
            #1;
            check_eq("hold_result", rsp_result, held);
            check_eq("hold_cmd_ready", cmd_ready, 1'b0);
            check_eq("hold_rsp_valid", rsp_valid, 1'b1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_idle", cmd_ready, 1'b1);
        check_eq("hold_flags", flags_nzcv, exp_flags);

        // Reset during ISSUE discards the op.
        run_op(3'b010, 32'd5, 32'd5, 6'd0, 4'hE, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_control = 3'b001;
        cmd_op0 = 32'h7FFF_FFFF;
        cmd_op1 = 32'h1;
        cmd_cond = 4'hE;
        cmd_set_flags = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_eq("rst_mid_alu_ctl", alu_control, 3'b001);
        #2;
        rst_n = 1'b0;
        #1;
        exp_flags = 4'b0000;
        check_eq("rst_mid_flags", flags_nzcv, 4'b0000);
        check_eq("rst_mid_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_mid_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_mid_alu_ctl0", alu_control, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("post_rst_no_rsp", rsp_valid, 1'b0);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = (i % 3 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            run_op(3'($urandom_range(0, 7)), a, b, 6'($urandom_range(0, 40)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
